// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
// apb_slave_pkg : shared APB encodings, response codes and default widths
// Revision      : 1.0
// ============================================================================
package apb_slave_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 8;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } apb_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// apb_slave_regfile : DEPTH x DATA_WIDTH registers, sync write, async read
// Revision          : 1.0
// ============================================================================
module apb_slave_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Guard keeps non-power-of-two depths from indexing past the array.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
// apb_slave : APB completer with wait states, range and protocol checking
// Revision  : 1.0
// ============================================================================
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e            state_q;
  logic [3:0]            count_q;
  logic                  err_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic                  ready;
  logic                  mismatch;
  logic                  complete;
  logic                  commit;
  logic                  read_drive;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic [DATA_WIDTH-1:0] read_val;

  assign ready      = (state_q == ST_ERR) || ((state_q == ST_ACCESS) && (count_q == 4'd0));
  assign mismatch   = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);
  assign complete   = (state_q == ST_ACCESS) && (count_q == 4'd0) && PSEL && PENABLE;
  // A violation sampled on the completing edge itself still blocks the write.
  assign commit     = complete && write_q && !err_q && !mismatch;
  assign read_drive = (state_q == ST_ACCESS) && (count_q == 4'd0) && !write_q;
  assign read_val   = err_q ? '0 : rf_rdata;

  assign PREADY  = ready;
  assign PSLVERR = ready && (err_q || (state_q == ST_ERR)) ? RESP_SLVERR : RESP_OKAY;
  assign PRDATA  = read_drive ? read_val : prdata_q;

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (commit),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (rf_rdata)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      count_q  <= 4'd0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      if (read_drive) begin
        prdata_q <= read_val;
      end
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            count_q <= WAIT_INIT;
            err_q   <= !addr_in_range(32'(PADDR), DEPTH);
            state_q <= ST_ACCESS;
          end else if (PSEL && PENABLE) begin
            state_q <= ST_ERR;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (mismatch) begin
              err_q <= 1'b1;
            end
            if (count_q != 4'd0) begin
              count_q <= count_q - 4'd1;
            end else if (PENABLE) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
// tb_apb_slave : self-checking bench, two instances (0 and 3 wait states)
// Revision     : 1.0
// ============================================================================
module tb_apb_slave;

  localparam int DEPTH = 16;
  localparam int WA    = 0;
  localparam int WB    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  int         dsel = 0;

  logic       psel_a, psel_b;
  logic [7:0] prdata_a, prdata_b, prdata;
  logic       rdy_a, rdy_b, rdy, err_a, err_b, slverr;

  assign psel_a = psel && (dsel == 0);
  assign psel_b = psel && (dsel == 1);
  assign prdata = (dsel == 0) ? prdata_a : prdata_b;
  assign rdy    = (dsel == 0) ? rdy_a : rdy_b;
  assign slverr = (dsel == 0) ? err_a : err_b;

  logic [7:0] model [2][DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(WA)) u_dut_a (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(rdy_a), .PSLVERR(err_a));

  apb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(WB)) u_dut_b (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(rdy_b), .PSLVERR(err_b));

  function automatic int xfer_len();
    return 2 + ((dsel == 0) ? WA : WB);
  endfunction

  function automatic logic [7:0] expect_rd(input logic [7:0] a);
    return (a < DEPTH) ? model[dsel][a[3:0]] : 8'h00;
  endfunction

  task automatic go_idle();
    psel = 1'b0;
    penable = 1'b0;
  endtask

  // Entered and left 1 time unit after a rising edge; leaves the bus in access phase.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int cyc,
                      output int lowc, output logic bad);
    logic done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cyc = 1; lowc = 0; bad = 1'b0; rd = 8'h00; er = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (rdy === 1'b1) begin
        rd = prdata; er = slverr; done = 1'b1;
      end else begin
        lowc++;
        if (slverr !== 1'b0) bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) cyc = -1;
  endtask

  task automatic read_all_vs_model(input string tag);
    logic [7:0] rd; logic er, bad; int cyc, lowc;
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 8'(i), 8'h00, rd, er, cyc, lowc, bad);
      checks++;
      if (rd !== model[dsel][i] || er !== 1'b0) begin
        errors++;
        $display("FAIL %s addr %0d: got data %h err %b, want data %h err 0",
                 tag, i, rd, er, model[dsel][i]);
      end
    end
    go_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({prdata_a, rdy_a, err_a, prdata_b, rdy_b, err_b} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h/%b/%b b=%h/%b/%b, want all zero",
               prdata_a, rdy_a, err_a, prdata_b, rdy_b, err_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) model[s][i] = 8'h00;
    dsel = 0;
    read_all_vs_model("reset_regs");
  endtask

  task automatic test_write_read();
    logic [7:0] rd, a, d; logic er, bad; int cyc, lowc;
    dsel = 0;
    xfer(1'b1, 8'h03, 8'hA5, rd, er, cyc, lowc, bad);
    go_idle();
    model[0][3] = 8'hA5;
    checks++;
    if (cyc !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL wr_basic: got cycles %0d err %b, want 2 / 0", cyc, er);
    end
    xfer(1'b0, 8'h03, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== 8'hA5 || er !== 1'b0 || cyc !== 2) begin
      errors++; $display("FAIL rd_basic: got %h err %b cycles %0d, want a5 / 0 / 2", rd, er, cyc);
    end
    for (int n = 0; n < 12; n++) begin
      dsel = n % 2;
      a = 8'($urandom_range(0, 21));
      d = 8'($urandom);
      xfer(1'b1, a, d, rd, er, cyc, lowc, bad);
      go_idle();
      checks++;
      if (er !== (a >= DEPTH) || cyc !== xfer_len()) begin
        errors++; $display("FAIL rand_wr addr %h: got err %b cycles %0d, want %b / %0d",
                           a, er, cyc, (a >= DEPTH), xfer_len());
      end
      if (a < DEPTH) model[dsel][a[3:0]] = d;
      a = 8'($urandom_range(0, 21));
      xfer(1'b0, a, 8'h00, rd, er, cyc, lowc, bad);
      go_idle();
      checks++;
      if (rd !== expect_rd(a) || er !== (a >= DEPTH)) begin
        errors++; $display("FAIL rand_rd addr %h: got %h err %b, want %h / %b",
                           a, rd, er, expect_rd(a), (a >= DEPTH));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] rd; logic er, bad; int cyc, lowc;
    dsel = 1;
    xfer(1'b1, 8'h07, 8'h5A, rd, er, cyc, lowc, bad);
    go_idle();
    model[1][7] = 8'h5A;
    checks++;
    if (cyc !== 5 || lowc !== 3 || bad !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL wait_wr: got cycles %0d low %0d bad %b err %b, want 5 / 3 / 0 / 0",
                         cyc, lowc, bad, er);
    end
    xfer(1'b0, 8'h07, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== 8'h5A || cyc !== 5) begin
      errors++; $display("FAIL wait_rd: got %h cycles %0d, want 5a / 5", rd, cyc);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd, a; logic er, bad; int cyc, lowc;
    dsel = 0;
    xfer(1'b1, 8'h10, 8'hFF, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (er !== 1'b1 || cyc !== 2) begin
      errors++; $display("FAIL oor_wr: got err %b cycles %0d, want 1 / 2", er, cyc);
    end
    xfer(1'b0, 8'h10, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== 8'h00 || er !== 1'b1) begin
      errors++; $display("FAIL oor_rd: got %h err %b, want 00 / 1", rd, er);
    end
    read_all_vs_model("oor_regs");
    dsel = 1;
    a = 8'($urandom_range(16, 255));
    xfer(1'b0, a, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== 8'h00 || er !== 1'b1 || cyc !== 5) begin
      errors++; $display("FAIL oor_rd_wait addr %h: got %h err %b cycles %0d, want 00 / 1 / 5",
                         a, rd, er, cyc);
    end
  endtask

  task automatic test_no_setup();
    logic [7:0] rd; logic er, bad; int cyc, lowc;
    dsel = 0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h11;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL nosetup_idle: got ready %b, want 0", rdy);
    end
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || slverr !== 1'b1) begin
      errors++; $display("FAIL nosetup_err: got ready %b err %b, want 1 / 1", rdy, slverr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || slverr !== 1'b0) begin
      errors++; $display("FAIL nosetup_after: got ready %b err %b, want 0 / 0", rdy, slverr);
    end
    @(posedge clk); #1;
    xfer(1'b0, 8'h03, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== model[0][3]) begin
      errors++; $display("FAIL nosetup_reg: got %h, want %h", rd, model[0][3]);
    end
  endtask

  task automatic test_addr_change();
    logic [7:0] rd; logic er, bad, got; int cyc, lowc;
    dsel = 1;
    xfer(1'b1, 8'h02, 8'h22, rd, er, cyc, lowc, bad);
    xfer(1'b1, 8'h04, 8'h44, rd, er, cyc, lowc, bad);
    go_idle();
    model[1][2] = 8'h22; model[1][4] = 8'h44;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'hEE;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    paddr = 8'h04;
    got = 1'b0; er = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin got = 1'b1; er = slverr; end
      @(posedge clk); #1;
    end
    go_idle();
    checks++;
    if (got !== 1'b1 || er !== 1'b1) begin
      errors++; $display("FAIL addr_change: got ready %b err %b, want 1 / 1", got, er);
    end
    for (int i = 2; i <= 4; i += 2) begin
      xfer(1'b0, 8'(i), 8'h00, rd, er, cyc, lowc, bad);
      go_idle();
      checks++;
      if (rd !== model[1][i]) begin
        errors++; $display("FAIL addr_change_reg %0d: got %h, want %h", i, rd, model[1][i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er, bad, seen; int cyc, lowc;
    dsel = 1;
    seen = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = ~model[1][5];
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); seen = seen | (rdy !== 1'b0);
    @(posedge clk); #1;
    go_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); seen = seen | (rdy !== 1'b0);
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_ready: got ready seen %b, want 0", seen);
    end
    xfer(1'b0, 8'h05, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    checks++;
    if (rd !== model[1][5] || er !== 1'b0) begin
      errors++; $display("FAIL abort_reg: got %h err %b, want %h / 0", rd, er, model[1][5]);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd; logic er, bad; int cyc, lowc;
    dsel = 1;
    xfer(1'b1, 8'h09, 8'h9C, rd, er, cyc, lowc, bad);
    xfer(1'b0, 8'h09, 8'h00, rd, er, cyc, lowc, bad);
    go_idle();
    model[1][9] = 8'h9C;
    checks++;
    if (prdata_b !== 8'h9C) begin
      errors++; $display("FAIL prdata_hold: got %h, want 9c", prdata_b);
    end
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h09; pwdata = 8'h33;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (prdata_b !== 8'h00 || rdy_b !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %h/%b/%b, want 00/0/0", prdata_b, rdy_b, err_b);
    end
    go_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) model[s][i] = 8'h00;
    read_all_vs_model("reset_mid_regs");
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, d[3]; logic er, bad; int cyc, lowc;
    for (int s = 0; s < 2; s++) begin
      dsel = s;
      for (int i = 0; i < 3; i++) begin
        d[i] = 8'($urandom);
        xfer(1'b1, 8'(i), d[i], rd, er, cyc, lowc, bad);
        model[s][i] = d[i];
        checks++;
        if (cyc !== xfer_len() || er !== 1'b0) begin
          errors++; $display("FAIL b2b_wr dut %0d addr %0d: got cycles %0d err %b, want %0d / 0",
                             s, i, cyc, er, xfer_len());
        end
      end
      for (int i = 0; i < 3; i++) begin
        xfer(1'b0, 8'(i), 8'h00, rd, er, cyc, lowc, bad);
        checks++;
        if (cyc !== xfer_len() || rd !== model[s][i] || er !== 1'b0) begin
          errors++; $display("FAIL b2b_rd dut %0d addr %0d: got %h cycles %0d err %b, want %h / %0d / 0",
                             s, i, rd, cyc, er, model[s][i], xfer_len());
        end
      end
      go_idle();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_no_setup();
    test_addr_change();
    test_abort();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
